// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the CPU RAM bus responder and its storage array.
package ram_bus_pkg;

    localparam int   WORD_W   = 16;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        SERVE,
        LOAD_HI,
        LOAD_LO,
        LOAD_WR
    } state_e;

    // A 17-bit address lets a carry out of base+n count as out of range, so nothing aliases.
    function automatic logic addr_in_range(input logic [16:0] addr, input int unsigned depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/ram_bus_array.sv
// Single-port synchronous RAM with registered read; a write also returns the new data.
module ram_bus_array
    import ram_bus_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
        end else begin
            rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_bus_responder.sv
// Memory side of the CPU RAM bus plus a big-endian byte-stream loader that owns the RAM while busy.
module ram_bus_responder
    import ram_bus_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              wire_clock,
    input  logic              wire_reset,
    input  logic [15:0]       bus_RAM_ADDRESS,
    input  logic              wire_RW,
    input  logic [WORD_W-1:0] bus_RAM_DATA_IN,
    output logic [WORD_W-1:0] bus_RAM_DATA_OUT,
    input  logic              wire_load_start,
    input  logic [15:0]       bus_load_base,
    input  logic [15:0]       bus_load_count,
    input  logic [7:0]        bus_load_byte,
    input  logic              wire_load_valid,
    output logic              wire_load_ready,
    output logic              wire_busy,
    output logic              wire_load_done
);

    state_e            state_q, state_d;
    logic [15:0]       base_q, base_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       n_q, n_d;
    logic [7:0]        hi_q, hi_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

    logic [16:0]       load_addr;
    logic              cpu_in_range;
    logic              load_in_range;

    assign load_addr     = {1'b0, base_q} + {1'b0, n_q};
    assign cpu_in_range  = addr_in_range({1'b0, bus_RAM_ADDRESS}, DEPTH);
    assign load_in_range = addr_in_range(load_addr, DEPTH);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        n_d       = n_q;
        hi_d      = hi_q;
        word_d    = word_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = bus_RAM_ADDRESS[ADDR_W-1:0];
        ram_wdata = bus_RAM_DATA_IN;

        case (state_q)
            SERVE: begin
                ram_we  = (wire_RW == RW_WRITE) && cpu_in_range;
                rd_en_d = cpu_in_range;
                if (wire_load_start) begin
                    base_d  = bus_load_base;
                    count_d = bus_load_count;
                    n_d     = 16'd0;
                    if (bus_load_count == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD_HI;
                        // Read data is blanked for the whole load, starting the cycle busy rises.
                        rd_en_d = 1'b0;
                    end
                end
            end
            LOAD_HI: begin
                if (wire_load_valid) begin
                    hi_d    = bus_load_byte;
                    state_d = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (wire_load_valid) begin
                    word_d  = {hi_q, bus_load_byte};
                    state_d = LOAD_WR;
                end
            end
            LOAD_WR: begin
                ram_addr  = load_addr[ADDR_W-1:0];
                ram_wdata = word_q;
                ram_we    = load_in_range;
                if (n_q == count_q - 16'd1) begin
                    state_d = SERVE;
                    done_d  = 1'b1;
                end else begin
                    n_d     = n_q + 16'd1;
                    state_d = LOAD_HI;
                end
            end
            default: state_d = SERVE;
        endcase

        if (wire_reset) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            state_q <= SERVE;
            base_q  <= '0;
            count_q <= '0;
            n_q     <= '0;
            hi_q    <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            n_q     <= n_d;
            hi_q    <= hi_d;
            word_q  <= word_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
        end
    end

    ram_bus_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (wire_clock),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus_RAM_DATA_OUT = rd_en_q ? ram_rdata : '0;
    assign wire_load_ready  = (state_q == LOAD_HI) || (state_q == LOAD_LO);
    assign wire_busy        = (state_q != SERVE);
    assign wire_load_done   = done_q;

endmodule

// File: tb/tb_ram_bus_responder.sv
// Randomized self-checking bench for ram_bus_responder against a word-array memory model.
module tb_ram_bus_responder;

    logic        wire_clock = 1'b0;
    logic        wire_reset;
    logic [15:0] bus_RAM_ADDRESS;
    logic        wire_RW;
    logic [15:0] bus_RAM_DATA_IN;
    logic [15:0] bus_RAM_DATA_OUT;
    logic        wire_load_start;
    logic [15:0] bus_load_base;
    logic [15:0] bus_load_count;
    logic [7:0]  bus_load_byte;
    logic        wire_load_valid;
    logic        wire_load_ready;
    logic        wire_busy;
    logic        wire_load_done;

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] mem_m [4096];
    logic [15:0] load_words [16];

    always #5 wire_clock = ~wire_clock;

    ram_bus_responder dut (
        .wire_clock       (wire_clock),
        .wire_reset       (wire_reset),
        .bus_RAM_ADDRESS  (bus_RAM_ADDRESS),
        .wire_RW          (wire_RW),
        .bus_RAM_DATA_IN  (bus_RAM_DATA_IN),
        .bus_RAM_DATA_OUT (bus_RAM_DATA_OUT),
        .wire_load_start  (wire_load_start),
        .bus_load_base    (bus_load_base),
        .bus_load_count   (bus_load_count),
        .bus_load_byte    (bus_load_byte),
        .wire_load_valid  (wire_load_valid),
        .wire_load_ready  (wire_load_ready),
        .wire_busy        (wire_busy),
        .wire_load_done   (wire_load_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge wire_clock);
        #1;
    endtask

    // One CPU bus transaction in SERVE; the expected value comes from the memory model.
    task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [15:0] d);
        logic [15:0] e;
        bus_RAM_ADDRESS = a;
        wire_RW         = rw;
        bus_RAM_DATA_IN = d;
        step();
        if (a < 16'd4096) begin
            if (rw) begin
                mem_m[a] = d;
                e = d;
            end else begin
                e = mem_m[a];
            end
        end else begin
            e = 16'h0000;
        end
        check(rw ? "cpu_wr" : "cpu_rd", {16'h0, bus_RAM_DATA_OUT}, {16'h0, e});
        $display("cpu %s addr=0x%04h data_out=0x%04h", rw ? "WR" : "RD", a, bus_RAM_DATA_OUT);
        wire_RW = 1'b0;
    endtask

    // Idle gap cycles hammer the bus with CPU writes and stray starts, all of which must be ignored.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        for (int g = 0; g < gap; g++) begin
            wire_load_valid = 1'b0;
            wire_RW         = 1'b1;
            bus_RAM_ADDRESS = 16'($urandom_range(0, 127));
            bus_RAM_DATA_IN = 16'($urandom);
            wire_load_start = ($urandom_range(0, 3) == 0);
            bus_load_count  = 16'd0;
            step();
            check("busy_in_load", {31'h0, wire_busy}, 32'd1);
            check("dout_in_load", {16'h0, bus_RAM_DATA_OUT}, 32'd0);
            check("done_in_load", {31'h0, wire_load_done}, 32'd0);
        end
        wire_load_start = 1'b0;
        wire_RW         = 1'b0;
        wire_load_valid = 1'b1;
        bus_load_byte   = b;
        k = 0;
        while (!wire_load_ready && k < 4) begin
            step();
            k++;
        end
        check("ready_for_byte", {31'h0, wire_load_ready}, 32'd1);
        step();
        wire_load_valid = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] base, input int count, input int max_gap);
        logic [16:0] a;
        bus_load_base   = base;
        bus_load_count  = 16'(count);
        wire_RW         = 1'b0;
        bus_RAM_ADDRESS = 16'h0000;
        wire_load_start = 1'b1;
        step();
        wire_load_start = 1'b0;
        if (count == 0) begin
            check("zero_busy", {31'h0, wire_busy}, 32'd0);
            check("zero_done", {31'h0, wire_load_done}, 32'd1);
            step();
            check("zero_done_end", {31'h0, wire_load_done}, 32'd0);
            check("zero_busy_end", {31'h0, wire_busy}, 32'd0);
            $display("load base=0x%04h count=0 done pulse seen", base);
            return;
        end
        check("load_busy_rise", {31'h0, wire_busy}, 32'd1);
        for (int w = 0; w < count; w++) begin
            send_byte(load_words[w][15:8], $urandom_range(0, max_gap));
            send_byte(load_words[w][7:0], $urandom_range(0, max_gap));
            check("ready_low_in_wr", {31'h0, wire_load_ready}, 32'd0);
            step();
            check("done_pulse", {31'h0, wire_load_done}, (w == count - 1) ? 32'd1 : 32'd0);
            check("busy_after_word", {31'h0, wire_busy}, (w == count - 1) ? 32'd0 : 32'd1);
            a = {1'b0, base} + 17'(w);
            if (a < 17'd4096) mem_m[a[11:0]] = load_words[w];
        end
        step();
        check("done_single", {31'h0, wire_load_done}, 32'd0);
        $display("load base=0x%04h count=%0d complete", base, count);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_m[i] = 16'h0000;
        wire_reset      = 1'b1;
        bus_RAM_ADDRESS = 16'h0;
        wire_RW         = 1'b0;
        bus_RAM_DATA_IN = 16'h0;
        wire_load_start = 1'b0;
        bus_load_base   = 16'h0;
        bus_load_count  = 16'h0;
        bus_load_byte   = 8'h0;
        wire_load_valid = 1'b0;
        step();
        step();
        check("rst_dout", {16'h0, bus_RAM_DATA_OUT}, 32'd0);
        check("rst_ready", {31'h0, wire_load_ready}, 32'd0);
        check("rst_busy", {31'h0, wire_busy}, 32'd0);
        check("rst_done", {31'h0, wire_load_done}, 32'd0);
        wire_reset = 1'b0;

        cpu_cycle(16'h0005, 1'b0, 16'h0);
        cpu_cycle(16'h0010, 1'b1, 16'h1234);
        cpu_cycle(16'h0010, 1'b0, 16'h0);
        cpu_cycle(16'h1000, 1'b0, 16'h0);
        cpu_cycle(16'h1000, 1'b1, 16'hBEEF);
        cpu_cycle(16'h0000, 1'b0, 16'h0);

        load_words[0] = 16'hABCD;
        load_words[1] = 16'h1234;
        do_load(16'h0020, 2, 3);
        cpu_cycle(16'h0020, 1'b0, 16'h0);
        cpu_cycle(16'h0021, 1'b0, 16'h0);

        do_load(16'h0030, 0, 0);
        cpu_cycle(16'h0030, 1'b0, 16'h0);

        load_words[0] = 16'h5A5A;
        load_words[1] = 16'hC3C3;
        do_load(16'h0FFF, 2, 1);
        cpu_cycle(16'h0FFF, 1'b0, 16'h0);
        cpu_cycle(16'h0000, 1'b0, 16'h0);

        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            case ($urandom_range(0, 7))
                0:       a = 16'($urandom_range(16'h0FF8, 16'h1008));
                1:       a = 16'($urandom);
                default: a = 16'($urandom_range(0, 127));
            endcase
            cpu_cycle(a, 1'($urandom), 16'($urandom));
        end

        for (int r = 0; r < 4; r++) begin
            int cnt;
            logic [15:0] b;
            cnt = $urandom_range(1, 4);
            b   = 16'($urandom_range(0, 120));
            for (int w = 0; w < cnt; w++) load_words[w] = 16'($urandom);
            do_load(b, cnt, 2);
            for (int w = 0; w < cnt; w++) cpu_cycle(b + 16'(w), 1'b0, 16'h0);
        end

        // Reset after the first word of a three-word load lands.
        cpu_cycle(16'h0041, 1'b1, 16'h7E7E);
        load_words[0] = 16'hD00D;
        bus_load_base   = 16'h0040;
        bus_load_count  = 16'd3;
        wire_load_start = 1'b1;
        step();
        wire_load_start = 1'b0;
        send_byte(8'hD0, 1);
        send_byte(8'h0D, 0);
        step();
        mem_m[16'h0040] = 16'hD00D;
        send_byte(8'h99, 0);
        wire_reset = 1'b1;
        step();
        wire_reset = 1'b0;
        check("abort_busy", {31'h0, wire_busy}, 32'd0);
        check("abort_ready", {31'h0, wire_load_ready}, 32'd0);
        check("abort_done", {31'h0, wire_load_done}, 32'd0);
        check("abort_dout", {16'h0, bus_RAM_DATA_OUT}, 32'd0);
        $display("reset mid-load applied");
        cpu_cycle(16'h0040, 1'b0, 16'h0);
        cpu_cycle(16'h0041, 1'b0, 16'h0);
        check("abort_busy_after", {31'h0, wire_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
